// File: rtl/shazam_pkg.sv
// Shared types and helpers for the constellation-hash pipeline.
// Latency: n/a (types, constants and a pure packing function only).
// Backpressure: n/a.
package shazam_pkg;

    localparam int IDX_W  = 9;
    localparam int MAG_W  = 16;
    localparam int TIME_W = 16;
    localparam int DT_W   = 6;
    localparam int HASH_W = 2 * IDX_W + DT_W;

    // History entry. The timestamp field is 'ts' because 'time' is a reserved word.
    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [TIME_W-1:0] ts;
        logic              valid;
    } peak_entry_t;

    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t IDLE = 2'd0;
    localparam fsm_state_t EMIT = 2'd1;
    localparam fsm_state_t PUSH = 2'd2;

    // Hash layout seen by the matcher: {anchor_idx, target_idx, dt}.
    function automatic logic [HASH_W-1:0] make_hash(input logic [IDX_W-1:0] anchor_idx,
                                                   input logic [IDX_W-1:0] target_idx,
                                                   input logic [DT_W-1:0]  dt);
        return {anchor_idx, target_idx, dt};
    endfunction

endpackage

// File: rtl/peak_history_ring.sv
// Newest-first shift register of recent frame peaks; entry 0 is the most recent.
// Latency: push/clear take effect on the next clock; read port is combinational.
// Backpressure: none; the owner decides when to push.
module peak_history_ring
    import shazam_pkg::*;
#(
    parameter int FAN_OUT = 4,
    parameter int K_W     = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              clear,
    input  peak_entry_t       push_entry,
    input  logic [K_W-1:0]    rd_k,
    output peak_entry_t       rd_entry
);

    peak_entry_t entries [FAN_OUT];

    // Shift in at the head; the oldest entry falls off the tail.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FAN_OUT; i++) entries[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < FAN_OUT; i++) entries[i] <= '0;
        end else if (push) begin
            entries[0] <= push_entry;
            for (int i = 1; i < FAN_OUT; i++) entries[i] <= entries[i-1];
        end
    end

    assign rd_entry = entries[rd_k];

endmodule

// File: rtl/peak_pair_hasher.sv
// Pairs each qualifying frame peak with up to FAN_OUT recent anchors and streams constellation hashes.
// Latency: first hash 1 cycle after the target is loaded; a target with no eligible anchor takes 2 cycles.
// Backpressure: hash stream is valid/ready; upstream cannot stall, so one pending slot absorbs and overflow_cnt counts drops.
// Optional: define PEAK_PAIR_HASHER_STATS_EN to add pairs_emitted / silent_frames counters.
module peak_pair_hasher
    import shazam_pkg::*;
#(
    parameter int FAN_OUT = 4,
    parameter int MAX_DT  = 32,
    parameter int MIN_MAG = 256
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                peak_valid,
    input  logic [24:0]         peak_in,
    output logic                hash_valid,
    input  logic                hash_ready,
    output logic [HASH_W-1:0]   hash_out,
    output logic [TIME_W-1:0]   hash_time,
    output logic [TIME_W-1:0]   frame_time,
    output logic                busy,
    output logic [7:0]          overflow_cnt
`ifdef PEAK_PAIR_HASHER_STATS_EN
    ,
    output logic [31:0]         pairs_emitted,
    output logic [15:0]         silent_frames
`endif
);

    localparam int                K_W       = (FAN_OUT > 1) ? $clog2(FAN_OUT) : 1;
    localparam logic [K_W-1:0]    K_LAST    = K_W'(FAN_OUT - 1);
    localparam logic [MAG_W-1:0]  MIN_MAG_L = MAG_W'(MIN_MAG);
    localparam logic [TIME_W-1:0] MAX_DT_L  = TIME_W'(MAX_DT);

    logic [IDX_W-1:0]  in_idx;
    logic [MAG_W-1:0]  in_mag;
    logic              qualify;

    fsm_state_t        state;
    logic [K_W-1:0]    k;
    logic [IDX_W-1:0]  cur_idx;
    logic [TIME_W-1:0] cur_time;

    logic              pending_vld;
    logic [IDX_W-1:0]  pending_idx;
    logic [TIME_W-1:0] pending_time;

    peak_entry_t       anchor;
    peak_entry_t       push_entry;
    logic [TIME_W-1:0] dt_full;
    logic              eligible;
    logic              fire;

    assign in_idx  = peak_in[24:16];
    assign in_mag  = peak_in[15:0];
    assign qualify = peak_valid && (in_mag >= MIN_MAG_L);

    assign push_entry = '{idx: cur_idx, ts: cur_time, valid: 1'b1};

    peak_history_ring #(
        .FAN_OUT (FAN_OUT),
        .K_W     (K_W)
    ) u_ring (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (state == PUSH),
        .clear      (1'b0),
        .push_entry (push_entry),
        .rd_k       (k),
        .rd_entry   (anchor)
    );

    // Modulo subtraction handles frame-counter wrap. Entries are newest-first,
    // so the first ineligible one ends the walk.
    assign dt_full    = cur_time - anchor.ts;
    assign eligible   = anchor.valid && (dt_full <= MAX_DT_L);
    assign hash_valid = (state == EMIT) && eligible;
    assign fire       = hash_valid && hash_ready;
    assign hash_out   = hash_valid ? make_hash(anchor.idx, cur_idx, dt_full[DT_W-1:0]) : '0;
    assign hash_time  = hash_valid ? anchor.ts : '0;
    assign busy       = (state != IDLE) || pending_vld;

    // Frame counter advances on every peak, qualifying, silent or dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) frame_time <= '0;
        else if (peak_valid) frame_time <= frame_time + 1'b1;
    end

    // Pending slot: drained by the FSM in IDLE, refilled by arrivals that find the FSM occupied.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_vld  <= 1'b0;
            pending_idx  <= '0;
            pending_time <= '0;
            overflow_cnt <= '0;
        end else if (state == IDLE) begin
            // Pending hands over to the FSM; a simultaneous arrival takes its place.
            if (pending_vld) begin
                pending_vld <= qualify;
                if (qualify) begin
                    pending_idx  <= in_idx;
                    pending_time <= frame_time;
                end
            end
        end else if (qualify) begin
            if (!pending_vld) begin
                pending_vld  <= 1'b1;
                pending_idx  <= in_idx;
                pending_time <= frame_time;
            end else if (overflow_cnt != 8'hFF) begin
                overflow_cnt <= overflow_cnt + 8'd1;
            end
        end
    end

    // Target sequencing: load a target, walk anchors newest-first, then record it in history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            k        <= '0;
            cur_idx  <= '0;
            cur_time <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending_vld) begin
                        cur_idx  <= pending_idx;
                        cur_time <= pending_time;
                        k        <= '0;
                        state    <= EMIT;
                    end else if (qualify) begin
                        cur_idx  <= in_idx;
                        cur_time <= frame_time;
                        k        <= '0;
                        state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (!eligible) begin
                        state <= PUSH;
                    end else if (hash_ready) begin
                        if (k == K_LAST) state <= PUSH;
                        else             k     <= k + 1'b1;
                    end
                end
                PUSH:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PEAK_PAIR_HASHER_STATS_EN
    // Activity counters: handshaken pairs (wrapping) and sub-threshold frames (saturating).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pairs_emitted <= '0;
            silent_frames <= '0;
        end else begin
            if (fire) pairs_emitted <= pairs_emitted + 32'd1;
            if (peak_valid && !qualify && (silent_frames != 16'hFFFF))
                silent_frames <= silent_frames + 16'd1;
        end
    end
`else
    logic unused_fire;
    assign unused_fire = fire;
`endif

endmodule

// File: tb/tb_peak_pair_hasher.sv
// Self-checking bench for peak_pair_hasher: directed scenarios plus a randomized run against a list-based model.
// Latency: n/a.
// Backpressure: hash_ready driven fixed or randomized per scenario.
module tb_peak_pair_hasher;

    localparam int FAN_OUT = 4;
    localparam int MAX_DT  = 32;
    localparam int MIN_MAG = 256;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        peak_valid;
    logic [24:0] peak_in;
    logic        hash_valid;
    logic        hash_ready;
    logic [23:0] hash_out;
    logic [15:0] hash_time;
    logic [15:0] frame_time;
    logic        busy;
    logic [7:0]  overflow_cnt;
`ifdef PEAK_PAIR_HASHER_STATS_EN
    logic [31:0] pairs_emitted;
    logic [15:0] silent_frames;
`endif

    always #5 clk = ~clk;

    peak_pair_hasher #(.FAN_OUT(FAN_OUT), .MAX_DT(MAX_DT), .MIN_MAG(MIN_MAG)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .peak_valid   (peak_valid),
        .peak_in      (peak_in),
        .hash_valid   (hash_valid),
        .hash_ready   (hash_ready),
        .hash_out     (hash_out),
        .hash_time    (hash_time),
        .frame_time   (frame_time),
        .busy         (busy),
        .overflow_cnt (overflow_cnt)
`ifdef PEAK_PAIR_HASHER_STATS_EN
        ,
        .pairs_emitted(pairs_emitted),
        .silent_frames(silent_frames)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit rand_ready = 0;

    // {hash[23:0], anchor_time[15:0]}
    logic [39:0] got_q[$];
    logic [39:0] exp_q[$];

    // Model: every stored peak, newest first, and the frame clock.
    int st_idx[$];
    int st_t[$];
    int model_time = 0;

    // A handshake seen at the falling edge completes at the following rising edge.
    always @(negedge clk) begin
        if (reset_n && hash_valid && hash_ready) got_q.push_back({hash_out, hash_time});
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) hash_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic model_peak(input int idx, input int mag, input bit dropped);
        int t;
        logic [39:0] e;
        t = model_time;
        model_time = (model_time + 1) % 65536;
        if (mag < MIN_MAG || dropped) return;
        for (int j = 0; j < FAN_OUT && j < st_idx.size(); j++) begin
            int dt;
            dt = (t - st_t[j] + 65536) % 65536;
            if (dt > MAX_DT) break;
            e = 40'((longint'(st_idx[j]) << 31) | (longint'(idx) << 22) |
                    (longint'(dt) << 16) | longint'(st_t[j]));
            exp_q.push_back(e);
        end
        st_idx.push_front(idx);
        st_t.push_front(t);
    endtask

    task automatic send_peak(input int idx, input int mag, input bit dropped);
        logic [8:0]  i9;
        logic [15:0] m16;
        i9 = 9'(idx);
        m16 = 16'(mag);
        peak_in = {i9, m16};
        peak_valid = 1'b1;
        tick();
        peak_valid = 1'b0;
        model_peak(idx, mag, dropped);
    endtask

    task automatic model_clear();
        model_time = 0;
        st_idx.delete();
        st_t.delete();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        peak_valid = 1'b0;
        hash_ready = 1'b0;
        rand_ready = 0;
        tick();
        tick();
        reset_n = 1'b1;
        model_clear();
        tick();
    endtask

    task automatic drain(output bit ok);
        ok = 0;
        for (int c = 0; c < 1000; c++) begin
            if (!busy) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        checks++; if (hash_valid !== 1'b0) begin errors++; $display("FAIL reset_hash_valid got %b exp 0", hash_valid); end
        checks++; if (hash_out !== 24'd0) begin errors++; $display("FAIL reset_hash_out got %h exp 0", hash_out); end
        checks++; if (frame_time !== 16'd0) begin errors++; $display("FAIL reset_frame_time got %0d exp 0", frame_time); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (overflow_cnt !== 8'd0) begin errors++; $display("FAIL reset_overflow got %0d exp 0", overflow_cnt); end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        hash_ready = 1'b1;
        send_peak(100, 1000, 0);
        checks++; if (frame_time !== 16'd1) begin errors++; $display("FAIL single_frame_time got %0d exp 1", frame_time); end
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", busy); end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL single_no_hash got %0d exp 0", got_q.size()); end
    endtask

    task automatic test_three();
        logic [39:0] lit [3];
        bit ok;
        do_reset();
        hash_ready = 1'b1;
        lit[0] = {9'd10, 9'd20, 6'd1, 16'd0};
        lit[1] = {9'd20, 9'd30, 6'd1, 16'd1};
        lit[2] = {9'd10, 9'd30, 6'd2, 16'd0};
        send_peak(10, 500, 0); drain(ok);
        send_peak(20, 500, 0); drain(ok);
        send_peak(30, 500, 0); drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL three_drain got busy exp idle"); end
        checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL three_count got %0d exp 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== lit[i]) begin errors++; $display("FAIL three_hash[%0d] got %h exp %h", i, got_q[i], lit[i]); end
        end
    endtask

    task automatic test_fanout();
        bit ok;
        do_reset();
        hash_ready = 1'b1;
        for (int p = 0; p < 6; p++) begin
            send_peak(100 + 7 * p, 500 + p, 0);
            drain(ok);
        end
        checks++; if (!ok) begin errors++; $display("FAIL fanout_drain got busy exp idle"); end
        checks++; if (got_q.size() !== 14) begin errors++; $display("FAIL fanout_count got %0d exp 14", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL fanout_hash[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        for (int j = 0; j < 4 && 10 + j < got_q.size(); j++) begin
            logic [39:0] g;
            g = got_q[10 + j];
            checks++;
            if (g[21:16] !== 6'(j + 1) || g[15:0] !== 16'(4 - j))
                begin errors++; $display("FAIL fanout_sixth[%0d] got dt %0d t %0d exp dt %0d t %0d", j, g[21:16], g[15:0], j + 1, 4 - j); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int n0;
        logic [39:0] sx;
        do_reset();
        hash_ready = 1'b1;
        send_peak(11, 500, 0); drain(ok);
        send_peak(22, 500, 0); drain(ok);
        hash_ready = 1'b0;
        n0 = exp_q.size();
        send_peak(33, 500, 0);
        sx = exp_q[n0];
        for (int c = 0; c < 20; c++) begin
            if (c == 2)      send_peak(44, 500, 0);
            else if (c == 5) send_peak(55, 500, 1);
            else             tick();
            checks++;
            if (hash_valid !== 1'b1 || hash_out !== sx[39:16] || hash_time !== sx[15:0])
                begin errors++; $display("FAIL bp_stable[%0d] got %b %h %0d exp 1 %h %0d", c, hash_valid, hash_out, hash_time, sx[39:16], sx[15:0]); end
        end
        checks++; if (overflow_cnt !== 8'd1) begin errors++; $display("FAIL bp_overflow got %0d exp 1", overflow_cnt); end
        hash_ready = 1'b1;
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_drain got busy exp idle"); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_hash[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_long_gap();
        bit ok;
        do_reset();
        hash_ready = 1'b1;
        send_peak(50, 600, 0);
        for (int s = 0; s < 40; s++) send_peak($urandom_range(0, 511), $urandom_range(0, MIN_MAG - 1), 0);
        send_peak(60, 900, 0);
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL gap_drain got busy exp idle"); end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL gap_no_hash got %0d exp 0", got_q.size()); end
        checks++; if (frame_time !== 16'd42) begin errors++; $display("FAIL gap_frame_time got %0d exp 42", frame_time); end
`ifdef PEAK_PAIR_HASHER_STATS_EN
        checks++; if (silent_frames !== 16'd40) begin errors++; $display("FAIL gap_silent got %0d exp 40", silent_frames); end
`endif
    endtask

    task automatic test_reset_mid_emit();
        bit ok;
        do_reset();
        hash_ready = 1'b1;
        send_peak(7, 800, 0); drain(ok);
        hash_ready = 1'b0;
        send_peak(8, 800, 0);
        checks++; if (hash_valid !== 1'b1) begin errors++; $display("FAIL mid_emit_valid got %b exp 1", hash_valid); end
        reset_n = 1'b0;
        #1;
        checks++; if (hash_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b exp 0", hash_valid); end
        tick();
        reset_n = 1'b1;
        model_clear();
        hash_ready = 1'b1;
        tick();
        send_peak(9, 800, 0);
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_drain got busy exp idle"); end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL mid_no_hash got %0d exp 0", got_q.size()); end
        checks++; if (overflow_cnt !== 8'd0) begin errors++; $display("FAIL mid_overflow got %0d exp 0", overflow_cnt); end
    endtask

    task automatic test_random();
        bit ok;
        bit all_ok;
        int nsub;
        do_reset();
        rand_ready = 1;
        all_ok = 1;
        for (int it = 0; it < 80; it++) begin
            nsub = ($urandom_range(0, 9) == 0) ? $urandom_range(30, 40) : $urandom_range(0, 2);
            for (int s = 0; s < nsub; s++) send_peak($urandom_range(0, 511), $urandom_range(0, MIN_MAG - 1), 0);
            send_peak($urandom_range(0, 511), $urandom_range(0, 1500), 0);
            if ($urandom_range(0, 2) == 0) send_peak($urandom_range(0, 511), $urandom_range(MIN_MAG, 1500), 0);
            drain(ok);
            if (!ok) all_ok = 0;
        end
        rand_ready = 0;
        hash_ready = 1'b1;
        checks++; if (!all_ok) begin errors++; $display("FAIL rand_drain got busy exp idle"); end
        checks++; if (frame_time !== 16'(model_time)) begin errors++; $display("FAIL rand_frame_time got %0d exp %0d", frame_time, model_time); end
        checks++; if (overflow_cnt !== 8'd0) begin errors++; $display("FAIL rand_overflow got %0d exp 0", overflow_cnt); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_hash[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
        end
`ifdef PEAK_PAIR_HASHER_STATS_EN
        checks++; if (pairs_emitted !== 32'(exp_q.size())) begin errors++; $display("FAIL rand_pairs got %0d exp %0d", pairs_emitted, exp_q.size()); end
`endif
    endtask

    initial begin
        reset_n = 1'b0;
        peak_valid = 1'b0;
        peak_in = '0;
        hash_ready = 1'b0;
        test_reset();
        test_single();
        test_three();
        test_fanout();
        test_backpressure();
        test_long_gap();
        test_reset_mid_emit();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
